// File: rtl/axis_bram_pkg.sv
// Shared types and helpers for the ping-pong AXI4-Stream to BRAM writer.
package axis_bram_pkg;

    // Writer FSM: wait for a free bank, fill it, or discard the rest of an oversized frame
    typedef enum logic [1:0] {
        SELECT = 2'd0,
        FILL   = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    // Words per bank: the top address bit selects the bank
    function automatic int unsigned bank_depth(input int unsigned addr_width);
        return 32'd1 << (addr_width - 1);
    endfunction

endpackage

// File: rtl/bram_bank_tracker.sv
// Per-bank completion bookkeeping: ready flags, captured lengths, truncation flags
// and the sticky overflow indicator. A set always wins over a release of the same bank.
module bram_bank_tracker
    import axis_bram_pkg::*;
#(
    parameter int LEN_W = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_en,
    input  logic             set_bank,
    input  logic [LEN_W-1:0] set_len,
    input  logic             set_trunc,
    input  logic [1:0]       rel,
    output logic [1:0]       frame_ready,
    output logic [LEN_W-1:0] frame_len0,
    output logic [LEN_W-1:0] frame_len1,
    output logic [1:0]       frame_trunc,
    output logic             overflow
);

    logic [1:0] set_hit;

    assign set_hit = {set_en & set_bank, set_en & ~set_bank};

    // Mark banks complete on frame close; consumer releases only affect ready banks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_ready <= '0;
            frame_trunc <= '0;
            frame_len0  <= '0;
            frame_len1  <= '0;
            overflow    <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (set_hit[i]) begin
                    frame_ready[i] <= 1'b1;
                    frame_trunc[i] <= set_trunc;
                end else if (rel[i] && frame_ready[i]) begin
                    frame_ready[i] <= 1'b0;
                    frame_trunc[i] <= 1'b0;
                end
            end
            if (set_hit[0]) frame_len0 <= set_len;
            if (set_hit[1]) frame_len1 <= set_len;
            if (set_en && set_trunc) overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/axis_s_bram_pingpong.sv
// AXI4-Stream slave writing tlast-delimited frames into a two-bank ping-pong BRAM.
// Holds the writer FSM, the bank offset counter and the registered BRAM write port.
module axis_s_bram_pingpong
    import axis_bram_pkg::*;
#(
    parameter int C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int BRAM_DEPTH             = 13
) (
    input  logic                                s00_axis_aclk,
    input  logic                                s00_axis_aresetn,
    output logic                                s00_axis_tready,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
    input  logic                                s00_axis_tlast,
    input  logic                                s00_axis_tvalid,
    input  logic                                bram_restart,
    input  logic [1:0]                          frame_release,
    output logic [1:0]                          frame_ready,
    output logic [BRAM_DEPTH-1:0]               frame_len0,
    output logic [BRAM_DEPTH-1:0]               frame_len1,
    output logic [1:0]                          frame_trunc,
    output logic                                overflow,
    output logic                                bram_clk,
    output logic                                bram_en,
    output logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] bram_we,
    output logic [BRAM_DEPTH-1:0]               bram_addr,
    output logic [C_S00_AXIS_TDATA_WIDTH-1:0]   bram_wdata
);

    localparam int OW = BRAM_DEPTH - 1;
    localparam logic [OW-1:0] OFS_LAST = OW'(bank_depth(BRAM_DEPTH) - 1);

    state_t                state;
    logic                  bank;
    logic                  next_bank;
    logic [OW-1:0]         wofs;
    logic                  beat;
    logic                  write_beat;
    logic                  set_en;
    logic                  set_trunc;
    logic [BRAM_DEPTH-1:0] set_len;

    assign bram_clk        = s00_axis_aclk;
    assign s00_axis_tready = (state != SELECT);
    assign beat            = s00_axis_tvalid & s00_axis_tready;
    assign write_beat      = (state == FILL) && beat && !bram_restart;
    assign set_trunc       = ~s00_axis_tlast;
    // A closing beat at the last offset yields BANK_DEPTH whether or not it carries tlast
    assign set_len         = {1'b0, wofs} + {{OW{1'b0}}, 1'b1};

    // Close the bank on tlast or when its last word is written
    always_comb begin
        set_en = 1'b0;
        if (write_beat && (s00_axis_tlast || (wofs == OFS_LAST))) set_en = 1'b1;
    end

    // Writer FSM: pick a free bank, fill it, drain an oversized frame's tail
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            state     <= SELECT;
            bank      <= 1'b0;
            next_bank <= 1'b0;
            wofs      <= '0;
        end else begin
            case (state)
                SELECT: begin
                    if (!frame_ready[next_bank]) begin
                        state <= FILL;
                        bank  <= next_bank;
                        wofs  <= '0;
                    end
                end
                FILL: begin
                    if (bram_restart) begin
                        state <= SELECT;
                    end else if (beat) begin
                        wofs <= wofs + 1'b1;
                        if (s00_axis_tlast) begin
                            state     <= SELECT;
                            next_bank <= ~bank;
                        end else if (wofs == OFS_LAST) begin
                            // Bank is already closed, so flip now; a restart while draining keeps it
                            state     <= DRAIN;
                            next_bank <= ~bank;
                        end
                    end
                end
                DRAIN: begin
                    if (bram_restart || (beat && s00_axis_tlast)) state <= SELECT;
                end
                default: state <= SELECT;
            endcase
        end
    end

    // Registered BRAM write port: one write per accepted beat, one cycle later
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            bram_en    <= 1'b0;
            bram_we    <= '0;
            bram_addr  <= '0;
            bram_wdata <= '0;
        end else begin
            bram_en <= 1'b1;
            if (write_beat) begin
                bram_we    <= s00_axis_tstrb;
                bram_addr  <= {bank, wofs};
                bram_wdata <= s00_axis_tdata;
            end else begin
                bram_we <= '0;
            end
        end
    end

    bram_bank_tracker #(
        .LEN_W(BRAM_DEPTH)
    ) u_tracker (
        .clk         (s00_axis_aclk),
        .rst_n       (s00_axis_aresetn),
        .set_en      (set_en),
        .set_bank    (bank),
        .set_len     (set_len),
        .set_trunc   (set_trunc),
        .rel         (frame_release),
        .frame_ready (frame_ready),
        .frame_len0  (frame_len0),
        .frame_len1  (frame_len1),
        .frame_trunc (frame_trunc),
        .overflow    (overflow)
    );

endmodule

// File: tb/tb_axis_s_bram_pingpong.sv
// Directed bench for axis_s_bram_pingpong (32-bit data, 13-bit BRAM address).
module tb_axis_s_bram_pingpong;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tready;
    logic [31:0] tdata = '0;
    logic [3:0]  tstrb = '0;
    logic        tlast = 1'b0;
    logic        tvalid = 1'b0;
    logic        restart = 1'b0;
    logic [1:0]  rel = '0;
    logic [1:0]  frame_ready;
    logic [12:0] len0;
    logic [12:0] len1;
    logic [1:0]  trunc;
    logic        overflow;
    logic        bram_clk;
    logic        bram_en;
    logic [3:0]  we;
    logic [12:0] addr;
    logic [31:0] wdata;

    int passed = 0;
    int total  = 0;

    logic [12:0] wa_q[$];
    logic [31:0] wd_q[$];
    logic [3:0]  ws_q[$];

    axis_s_bram_pingpong #(
        .C_S00_AXIS_TDATA_WIDTH(32),
        .BRAM_DEPTH(13)
    ) dut (
        .s00_axis_aclk    (clk),
        .s00_axis_aresetn (rst_n),
        .s00_axis_tready  (tready),
        .s00_axis_tdata   (tdata),
        .s00_axis_tstrb   (tstrb),
        .s00_axis_tlast   (tlast),
        .s00_axis_tvalid  (tvalid),
        .bram_restart     (restart),
        .frame_release    (rel),
        .frame_ready      (frame_ready),
        .frame_len0       (len0),
        .frame_len1       (len1),
        .frame_trunc      (trunc),
        .overflow         (overflow),
        .bram_clk         (bram_clk),
        .bram_en          (bram_en),
        .bram_we          (we),
        .bram_addr        (addr),
        .bram_wdata       (wdata)
    );

    always #5 clk = ~clk;

    // Record every BRAM write presented to the memory (sampled mid-cycle)
    always @(negedge clk) begin
        if (rst_n && we != 4'h0) begin
            wa_q.push_back(addr);
            wd_q.push_back(wdata);
            ws_q.push_back(we);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        ws_q.delete();
    endtask

    task automatic do_reset();
        tvalid = 1'b0; tlast = 1'b0; restart = 1'b0; rel = '0;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        clear_log();
    endtask

    // Offer one beat and hold it until accepted; returns at accept edge + 1
    task automatic send_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
        int waited = 0;
        tdata = d; tstrb = s; tlast = l; tvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (tready === 1'b1) break;
            waited++;
            if (waited > 50) begin
                total++;
                $display("FAIL beat_timeout: tready=%b after %0d cycles, required 1", tready, waited);
                break;
            end
        end
        @(posedge clk);
        #1;
        tvalid = 1'b0; tlast = 1'b0;
    endtask

    task automatic send_frame(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) send_beat(base + 32'(i), 4'hF, (i == n - 1));
    endtask

    task automatic test_reset();
        tick(2);
        total++; if (tready !== 1'b0) $display("FAIL rst_tready: got %b required 0", tready); else passed++;
        total++; if (bram_en !== 1'b0 || we !== 4'h0) $display("FAIL rst_en_we: got en=%b we=%h required 0/0", bram_en, we); else passed++;
        total++; if (addr !== 13'h0 || wdata !== 32'h0) $display("FAIL rst_addr_data: got %h/%h required 0/0", addr, wdata); else passed++;
        total++; if (frame_ready !== 2'b00 || trunc !== 2'b00 || overflow !== 1'b0) $display("FAIL rst_flags: got ready=%b trunc=%b ovf=%b required 00/00/0", frame_ready, trunc, overflow); else passed++;
        total++; if (len0 !== 13'd0 || len1 !== 13'd0) $display("FAIL rst_len: got %0d/%0d required 0/0", len0, len1); else passed++;
        rst_n = 1'b1;
        clear_log();
        tick(1);
        total++; if (bram_en !== 1'b1 || tready !== 1'b1) $display("FAIL rst_exit: got en=%b tready=%b required 1/1", bram_en, tready); else passed++;
    endtask

    task automatic test_basic_frame();
        int err = 0;
        send_beat(32'hA0, 4'hF, 1'b0);
        total++; if (we !== 4'hF || addr !== 13'd0 || wdata !== 32'hA0) $display("FAIL t1_latency: got we=%h addr=%0d data=%h required f/0/a0", we, addr, wdata); else passed++;
        send_beat(32'hA1, 4'hF, 1'b0);
        send_beat(32'hA2, 4'hF, 1'b0);
        send_beat(32'hA3, 4'hF, 1'b1);
        total++; if (frame_ready !== 2'b01 || len0 !== 13'd4) $display("FAIL t1_ready_len: got %b/%0d required 01/4", frame_ready, len0); else passed++;
        tick(1);
        if (wa_q.size() != 4) err++;
        else for (int i = 0; i < 4; i++) if (wa_q[i] !== 13'(i) || wd_q[i] !== 32'hA0 + 32'(i)) err++;
        total++; if (err != 0) $display("FAIL t1_writes: got %0d writes (%0d bad) required 4 at addr 0..3", wa_q.size(), err); else passed++;
    endtask

    task automatic test_second_bank_and_release();
        int err = 0;
        int seen_ready = 0;
        clear_log();
        send_frame(3, 32'hB0);
        tick(1);
        if (wa_q.size() != 3) err++;
        else for (int i = 0; i < 3; i++) if (wa_q[i] !== 13'd4096 + 13'(i) || wd_q[i] !== 32'hB0 + 32'(i)) err++;
        total++; if (err != 0) $display("FAIL t2_writes: got %0d writes (%0d bad) required 3 at 4096..4098", wa_q.size(), err); else passed++;
        total++; if (frame_ready !== 2'b11 || len1 !== 13'd3) $display("FAIL t2_ready_len: got %b/%0d required 11/3", frame_ready, len1); else passed++;
        clear_log();
        tdata = 32'hC0; tstrb = 4'hF; tlast = 1'b0; tvalid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (tready !== 1'b0) seen_ready++;
        end
        #1;
        total++; if (seen_ready != 0 || wa_q.size() != 0) $display("FAIL t2_blocked: got %0d ready cycles, %0d writes, required 0/0", seen_ready, wa_q.size()); else passed++;
        @(posedge clk); #1;
        rel = 2'b01;
        tick(1);
        rel = 2'b00;
        total++; if (frame_ready !== 2'b10) $display("FAIL t2_release: got %b required 10", frame_ready); else passed++;
        send_beat(32'hC0, 4'hF, 1'b0);
        send_beat(32'hC1, 4'hF, 1'b1);
        tick(1);
        err = 0;
        if (wa_q.size() != 2) err++;
        else for (int i = 0; i < 2; i++) if (wa_q[i] !== 13'(i) || wd_q[i] !== 32'hC0 + 32'(i)) err++;
        total++; if (err != 0) $display("FAIL t2_refill: got %0d writes (%0d bad) required 2 at addr 0..1", wa_q.size(), err); else passed++;
        total++; if (frame_ready !== 2'b11 || len0 !== 13'd2) $display("FAIL t2_refill_len: got %b/%0d required 11/2", frame_ready, len0); else passed++;
        rel = 2'b11;
        tick(1);
        rel = 2'b00;
        total++; if (frame_ready !== 2'b00) $display("FAIL t2_release_both: got %b required 00", frame_ready); else passed++;
    endtask

    task automatic test_truncation();
        int err = 0;
        do_reset();
        for (int i = 0; i < 4097; i++) send_beat(32'(i), 4'hF, (i == 4096));
        tick(1);
        if (wa_q.size() != 4096) err++;
        else for (int i = 0; i < 4096; i++) if (wa_q[i] !== 13'(i) || wd_q[i] !== 32'(i)) err++;
        total++; if (err != 0) $display("FAIL t3_writes: got %0d writes (%0d bad) required 4096 at 0..4095", wa_q.size(), err); else passed++;
        total++; if (trunc !== 2'b01 || overflow !== 1'b1) $display("FAIL t3_trunc: got trunc=%b ovf=%b required 01/1", trunc, overflow); else passed++;
        total++; if (frame_ready !== 2'b01 || len0 !== 13'd4096) $display("FAIL t3_len: got %b/%0d required 01/4096", frame_ready, len0); else passed++;
        send_beat(32'h55, 4'hF, 1'b1);
        tick(1);
        total++; if (wa_q.size() != 4097 || wa_q[wa_q.size()-1] !== 13'd4096 || wd_q[wd_q.size()-1] !== 32'h55) $display("FAIL t3_next_bank: got %0d writes, last addr %0d, required 4097 with last at 4096", wa_q.size(), wa_q[wa_q.size()-1]); else passed++;
        total++; if (frame_ready !== 2'b11 || len1 !== 13'd1 || trunc !== 2'b01) $display("FAIL t3_single_beat: got ready=%b len1=%0d trunc=%b required 11/1/01", frame_ready, len1, trunc); else passed++;
        rel = 2'b01;
        tick(1);
        rel = 2'b00;
        total++; if (trunc !== 2'b00 || overflow !== 1'b1 || frame_ready !== 2'b10) $display("FAIL t3_release: got trunc=%b ovf=%b ready=%b required 00/1/10", trunc, overflow, frame_ready); else passed++;
    endtask

    task automatic test_restart();
        int err = 0;
        do_reset();
        send_beat(32'hD0, 4'hF, 1'b0);
        send_beat(32'hD1, 4'hF, 1'b0);
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        tick(1);
        total++; if (frame_ready !== 2'b00) $display("FAIL t4_no_ready: got %b required 00", frame_ready); else passed++;
        clear_log();
        send_frame(3, 32'hE0);
        tick(1);
        if (wa_q.size() != 3) err++;
        else for (int i = 0; i < 3; i++) if (wa_q[i] !== 13'(i) || wd_q[i] !== 32'hE0 + 32'(i)) err++;
        total++; if (err != 0) $display("FAIL t4_same_bank: got %0d writes (%0d bad) required 3 at 0..2", wa_q.size(), err); else passed++;
        total++; if (frame_ready !== 2'b01 || len0 !== 13'd3) $display("FAIL t4_len: got %b/%0d required 01/3", frame_ready, len0); else passed++;
        send_beat(32'hF0, 4'hF, 1'b0);
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        tick(1);
        total++; if (frame_ready !== 2'b01 || len0 !== 13'd3) $display("FAIL t4_retained: got %b/%0d required 01/3", frame_ready, len0); else passed++;
        clear_log();
        send_frame(2, 32'hF8);
        tick(1);
        total++; if (wa_q.size() != 2 || wa_q[0] !== 13'd4096 || wa_q[1] !== 13'd4097) $display("FAIL t4_bank1: got %0d writes, first addr %0d, required 2 at 4096..4097", wa_q.size(), wa_q[0]); else passed++;
        total++; if (frame_ready !== 2'b11 || len1 !== 13'd2) $display("FAIL t4_bank1_len: got %b/%0d required 11/2", frame_ready, len1); else passed++;
    endtask

    task automatic test_async_reset();
        rel = 2'b01;
        tick(1);
        rel = 2'b00;
        send_beat(32'h60, 4'hF, 1'b0);
        send_beat(32'h61, 4'hF, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        total++; if (tready !== 1'b0 || bram_en !== 1'b0 || we !== 4'h0) $display("FAIL t5_async_port: got tready=%b en=%b we=%h required 0/0/0", tready, bram_en, we); else passed++;
        total++; if (addr !== 13'd0 || wdata !== 32'h0) $display("FAIL t5_async_data: got %h/%h required 0/0", addr, wdata); else passed++;
        total++; if (frame_ready !== 2'b00 || len1 !== 13'd0 || overflow !== 1'b0) $display("FAIL t5_async_flags: got ready=%b len1=%0d ovf=%b required 00/0/0", frame_ready, len1, overflow); else passed++;
        tick(1);
        rst_n = 1'b1;
        clear_log();
        send_frame(2, 32'h70);
        tick(1);
        total++; if (wa_q.size() != 2 || wa_q[0] !== 13'd0 || wd_q[0] !== 32'h70 || wa_q[1] !== 13'd1) $display("FAIL t5_clean: got %0d writes, first addr %0d, required 2 at 0..1", wa_q.size(), wa_q[0]); else passed++;
        total++; if (frame_ready !== 2'b01 || len0 !== 13'd2) $display("FAIL t5_len: got %b/%0d required 01/2", frame_ready, len0); else passed++;
    endtask

    task automatic test_strobe_gaps();
        logic [3:0] strbs [5];
        int err = 0;
        int gap;
        strbs[0] = 4'hF; strbs[1] = 4'b0101; strbs[2] = 4'hF; strbs[3] = 4'hA; strbs[4] = 4'h3;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            gap = int'($urandom_range(0, 3));
            tdata = 32'hDEAD0000 + 32'(i);
            if (gap > 0) tick(gap);
            send_beat(32'h90 + 32'(i), strbs[i], (i == 4));
        end
        tick(5);
        total++; if (ws_q.size() < 2 || ws_q[1] !== 4'b0101) $display("FAIL t6_strb: got %0d writes, we[1]=%b required 0101", ws_q.size(), (ws_q.size() >= 2) ? ws_q[1] : 4'h0); else passed++;
        if (wa_q.size() != 5) err++;
        else for (int i = 0; i < 5; i++) if (wa_q[i] !== 13'(i) || wd_q[i] !== 32'h90 + 32'(i) || ws_q[i] !== strbs[i]) err++;
        total++; if (err != 0) $display("FAIL t6_gaps: got %0d writes (%0d bad) required 5 at 0..4", wa_q.size(), err); else passed++;
        total++; if (frame_ready !== 2'b01 || len0 !== 13'd5) $display("FAIL t6_len: got %b/%0d required 01/5", frame_ready, len0); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_second_bank_and_release();
        test_truncation();
        test_restart();
        test_async_reset();
        test_strobe_gaps();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
